// File: rtl/cam_refill_ctrl.sv
// cam_refill_ctrl
// Control block for a small CAM built from external entry cells. It
// broadcasts the lookup key to every cell, qualifies the cells' raw hit
// lines with an internal entry-valid vector, and registers a one-cycle
// lookup response. It also serialises refills (install or invalidate) into
// a one-hot update pulse toward the cells, followed by a settle cycle that
// covers the cells' two-cycle write latency.
//
// Handshake: a request is accepted in any cycle in which its valid input and
// the matching ready output are both high. Ready is high only in IDLE. Valid
// may be raised in any cycle; the request is held by the requester until it
// is accepted.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   lookup_valid_i/_ready_o  lookup handshake
//   lookup_key_i             lookup key (also driven onto cmp_key_o)
//   resp_valid_o             one-cycle pulse following an accepted lookup
//   resp_hit_o/_multi_o/_idx_o  lookup result
//   refill_valid_i/_ready_o  refill handshake
//   refill_key_i             key to install
//   refill_inv_i             request is an invalidate of refill_idx_i
//   refill_idx_i             target entry of an invalidate
//   cmp_key_o                compare key to all entry cells
//   ent_hit_i                raw per-cell hit lines (same cycle as cmp_key_o)
//   ent_update_o             one-hot update strobe to the entry cells
//   ent_set_key_o/_valid_o   update payload to the entry cells
//   state_o                  current FSM state (debug observation)
module cam_refill_ctrl #(
  parameter int ENTRIES = 8,
  parameter int KEY_W   = 20,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_valid_i,
  input  logic [KEY_W-1:0]   lookup_key_i,
  output logic               lookup_ready_o,
  output logic               resp_valid_o,
  output logic               resp_hit_o,
  output logic               resp_multi_o,
  output logic [IDX_W-1:0]   resp_idx_o,
  input  logic               refill_valid_i,
  output logic               refill_ready_o,
  input  logic [KEY_W-1:0]   refill_key_i,
  input  logic               refill_inv_i,
  input  logic [IDX_W-1:0]   refill_idx_i,
  output logic [KEY_W-1:0]   cmp_key_o,
  input  logic [ENTRIES-1:0] ent_hit_i,
  output logic [ENTRIES-1:0] ent_update_o,
  output logic [KEY_W-1:0]   ent_set_key_o,
  output logic               ent_set_valid_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPD    = 2'd1,
    S_SETTLE = 2'd2
  } state_e;

  state_e             state_q;
  logic [ENTRIES-1:0] valid_q;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   upd_idx_q;
  logic [KEY_W-1:0]   upd_key_q;
  logic               upd_valid_q;
  logic               upd_use_rr_q;
  logic [ENTRIES-1:0] ent_update_q;
  logic               resp_valid_q;
  logic               resp_hit_q;
  logic               resp_multi_q;
  logic [IDX_W-1:0]   resp_idx_q;

  logic               idle;
  logic               lk_acc;
  logic               rf_acc;
  logic [ENTRIES-1:0] qhit;
  logic [IDX_W-1:0]   hit_idx;
  logic               hit_multi;
  logic               free_any;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic               use_rr;

  always_comb begin
    idle    = (state_q == S_IDLE);
    lk_acc  = lookup_valid_i && idle;
    rf_acc  = refill_valid_i && idle;
    // Raw cell hits only count for entries this block believes are valid.
    qhit    = ent_hit_i & valid_q;
    // Clearing the lowest set bit leaves something only if >= 2 bits set.
    hit_multi = |(qhit & (qhit - ENTRIES'(1)));
    free_any  = ~&valid_q;
    // Downward scans so the lowest set index wins.
    hit_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (qhit[i])     hit_idx  = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    use_rr = !refill_inv_i && !free_any;
    if (refill_inv_i)  victim = refill_idx_i;
    else if (free_any) victim = free_idx;
    else               victim = rr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      rr_q         <= '0;
      upd_idx_q    <= '0;
      upd_key_q    <= '0;
      upd_valid_q  <= 1'b0;
      upd_use_rr_q <= 1'b0;
      ent_update_q <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_multi_q <= 1'b0;
      resp_idx_q   <= '0;
    end else begin
      // A lookup accepted alongside a refill sees pre-refill contents,
      // since valid_q only changes in UPD.
      resp_valid_q <= lk_acc;
      resp_hit_q   <= lk_acc && (|qhit);
      resp_multi_q <= lk_acc && hit_multi;
      resp_idx_q   <= lk_acc ? hit_idx : '0;
      ent_update_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (rf_acc) begin
            state_q      <= S_UPD;
            upd_idx_q    <= victim;
            upd_key_q    <= refill_key_i;
            upd_valid_q  <= !refill_inv_i;
            upd_use_rr_q <= use_rr;
            // Registered so the strobe is high exactly during UPD.
            ent_update_q <= ENTRIES'(1) << victim;
          end
        end
        S_UPD: begin
          valid_q[upd_idx_q] <= upd_valid_q;
          // ENTRIES is a power of two, so the add wraps naturally.
          if (upd_use_rr_q) rr_q <= rr_q + IDX_W'(1);
          state_q <= S_SETTLE;
        end
        S_SETTLE: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign cmp_key_o       = lookup_key_i;
  assign lookup_ready_o  = idle;
  assign refill_ready_o  = idle;
  assign resp_valid_o    = resp_valid_q;
  assign resp_hit_o      = resp_hit_q;
  assign resp_multi_o    = resp_multi_q;
  assign resp_idx_o      = resp_idx_q;
  assign ent_update_o    = ent_update_q;
  assign ent_set_key_o   = upd_key_q;
  assign ent_set_valid_o = upd_valid_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_cam_refill_ctrl.sv
// Directed bench for cam_refill_ctrl (ENTRIES=8, KEY_W=20).
module tb_cam_refill_ctrl;

  localparam int ENTRIES = 8;
  localparam int KEY_W   = 20;
  localparam int IDX_W   = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               lookup_valid_i = 1'b0;
  logic [KEY_W-1:0]   lookup_key_i   = '0;
  logic               lookup_ready_o;
  logic               resp_valid_o, resp_hit_o, resp_multi_o;
  logic [IDX_W-1:0]   resp_idx_o;
  logic               refill_valid_i = 1'b0;
  logic               refill_ready_o;
  logic [KEY_W-1:0]   refill_key_i   = '0;
  logic               refill_inv_i   = 1'b0;
  logic [IDX_W-1:0]   refill_idx_i   = '0;
  logic [KEY_W-1:0]   cmp_key_o;
  logic [ENTRIES-1:0] ent_hit_i      = '0;
  logic [ENTRIES-1:0] ent_update_o;
  logic [KEY_W-1:0]   ent_set_key_o;
  logic               ent_set_valid_o;
  logic [1:0]         state_o;

  cam_refill_ctrl #(.ENTRIES(ENTRIES), .KEY_W(KEY_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_valid_i  (lookup_valid_i),
    .lookup_key_i    (lookup_key_i),
    .lookup_ready_o  (lookup_ready_o),
    .resp_valid_o    (resp_valid_o),
    .resp_hit_o      (resp_hit_o),
    .resp_multi_o    (resp_multi_o),
    .resp_idx_o      (resp_idx_o),
    .refill_valid_i  (refill_valid_i),
    .refill_ready_o  (refill_ready_o),
    .refill_key_i    (refill_key_i),
    .refill_inv_i    (refill_inv_i),
    .refill_idx_i    (refill_idx_i),
    .cmp_key_o       (cmp_key_o),
    .ent_hit_i       (ent_hit_i),
    .ent_update_o    (ent_update_o),
    .ent_set_key_o   (ent_set_key_o),
    .ent_set_valid_o (ent_set_valid_o),
    .state_o         (state_o)
  );

  // scoreboard: {hit, multi, idx} per lookup, {strobe, key, valid} per refill
  logic [4:0]  exp_q[$];
  logic [28:0] upd_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the cycle after a lookup was accepted.
  task automatic check_resp(input string tag);
    logic [4:0] e;
    chk({tag, "_rvalid"}, 32'(resp_valid_o), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_expq_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_resp"}, 32'({resp_hit_o, resp_multi_o, resp_idx_o}), 32'(e));
    end
  endtask

  // Called in the UPD cycle; walks through SETTLE back to IDLE.
  task automatic check_upd(input string tag);
    logic [28:0] e;
    if (upd_q.size() == 0) begin
      chk({tag, "_updq_empty"}, 32'd1, 32'd0);
    end else begin
      e = upd_q.pop_front();
      chk({tag, "_upd"}, 32'({ent_update_o, ent_set_key_o, ent_set_valid_o}), 32'(e));
    end
    chk({tag, "_rdy_t1"}, 32'({lookup_ready_o, refill_ready_o}), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_upd_t2"}, 32'(ent_update_o), 32'd0);
    chk({tag, "_rdy_t2"}, 32'({lookup_ready_o, refill_ready_o}), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_rdy_t3"}, 32'({lookup_ready_o, refill_ready_o}), 32'd3);
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic lookup(input string tag, input logic [KEY_W-1:0] key,
                        input logic [ENTRIES-1:0] hits,
                        input logic e_hit, input logic e_multi, input logic [IDX_W-1:0] e_idx);
    exp_q.push_back({e_hit, e_multi, e_idx});
    lookup_valid_i = 1'b1;
    lookup_key_i   = key;
    ent_hit_i      = hits;
    #1;
    chk({tag, "_cmpkey"}, 32'(cmp_key_o), 32'(key));
    chk({tag, "_lrdy"}, 32'(lookup_ready_o), 32'd1);
    @(posedge clk); #1;
    lookup_valid_i = 1'b0;
    ent_hit_i      = '0;
    check_resp(tag);
  endtask

  task automatic refill(input string tag, input logic [KEY_W-1:0] key,
                        input logic inv, input logic [IDX_W-1:0] idx,
                        input logic [IDX_W-1:0] e_victim);
    logic [ENTRIES-1:0] oh;
    oh = '0;
    oh[e_victim] = 1'b1;
    upd_q.push_back({oh, key, ~inv});
    refill_valid_i = 1'b1;
    refill_key_i   = key;
    refill_inv_i   = inv;
    refill_idx_i   = idx;
    chk({tag, "_frdy"}, 32'(refill_ready_o), 32'd1);
    @(posedge clk); #1;
    refill_valid_i = 1'b0;
    chk({tag, "_rvalid0"}, 32'(resp_valid_o), 32'd0);
    check_upd(tag);
  endtask

  initial begin
    // reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp", 32'({resp_hit_o, resp_multi_o, resp_idx_o}), 32'd0);
    chk("rst_upd", 32'(ent_update_o), 32'd0);
    chk("rst_rdy", 32'({lookup_ready_o, refill_ready_o}), 32'd3);
    rst = 1'b0;
    @(posedge clk); #1;

    // all entries invalid after reset: miss even with every raw hit set
    lookup("lk_after_rst", 20'h12345, 8'hFF, 1'b0, 1'b0, 3'd0);
    @(posedge clk); #1;
    chk("rvalid_idle", 32'(resp_valid_o), 32'd0);

    // first install lands in entry 0
    refill("inst_abc", 20'h00ABC, 1'b0, 3'd0, 3'd0);
    // fill the remaining free entries in order
    for (int v = 1; v < 8; v++) refill("fill", KEY_W'(20'h100 + v), 1'b0, 3'd0, IDX_W'(v));
    // full: round-robin victims 0,1,2
    for (int v = 0; v < 3; v++) refill("rr", KEY_W'(20'h200 + v), 1'b0, 3'd0, IDX_W'(v));

    // invalidate 5, then it no longer hits and is the next install victim
    refill("inv5", 20'h0, 1'b1, 3'd5, 3'd5);
    lookup("lk_inv5", 20'h00105, 8'h20, 1'b0, 1'b0, 3'd0);
    refill("inst_free5", 20'h00777, 1'b0, 3'd0, 3'd5);
    // full again: round-robin resumes at 3
    refill("rr3", 20'h00333, 1'b0, 3'd0, 3'd3);

    // qualified hit patterns
    lookup("lk_28", 20'h00AAA, 8'h28, 1'b1, 1'b1, 3'd3);
    lookup("lk_00", 20'h00BBB, 8'h00, 1'b0, 1'b0, 3'd0);
    lookup("lk_80", 20'h00CCC, 8'h80, 1'b1, 1'b0, 3'd7);
    lookup("lk_ff", 20'h00DDD, 8'hFF, 1'b1, 1'b1, 3'd0);

    // lookup and invalidate of entry 3 in the same cycle: lookup sees old contents
    exp_q.push_back({1'b1, 1'b0, 3'd3});
    upd_q.push_back({8'h08, 20'h00000, 1'b1 ^ 1'b1});
    lookup_valid_i = 1'b1; lookup_key_i = 20'h00333; ent_hit_i = 8'h08;
    refill_valid_i = 1'b1; refill_key_i = 20'h0; refill_inv_i = 1'b1; refill_idx_i = 3'd3;
    @(posedge clk); #1;
    lookup_valid_i = 1'b0; refill_valid_i = 1'b0; ent_hit_i = '0;
    check_resp("both");
    check_upd("both");
    lookup("lk_after_inv3", 20'h00333, 8'h08, 1'b0, 1'b0, 3'd0);

    // reset during UPD kills the pending strobe
    refill_valid_i = 1'b1; refill_key_i = 20'h0DEAD; refill_inv_i = 1'b0;
    @(posedge clk); #1;
    refill_valid_i = 1'b0;
    chk("mid_upd_strobe", 32'(ent_update_o), 32'h08);
    rst = 1'b1;
    #1;
    chk("mid_rst_drop", 32'(ent_update_o), 32'd0);
    chk("mid_rst_rdy", 32'(lookup_ready_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rdy", 32'({lookup_ready_o, refill_ready_o}), 32'd3);
    chk("post_rst_upd", 32'(ent_update_o), 32'd0);
    lookup("lk_post_rst", 20'h0DEAD, 8'hFF, 1'b0, 1'b0, 3'd0);
    refill("inst_post_rst", 20'h00F00, 1'b0, 3'd0, 3'd0);

    chk("expq_drained", 32'(exp_q.size()), 32'd0);
    chk("updq_drained", 32'(upd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
